// File: rtl/params_pkg.sv
// Shared widths, device ids and DROM loader types for the CPU fetch path.
package params_pkg;
    localparam int ADDR_W      = 32;
    localparam int INSTR_W     = 32;
    localparam int INSTR_BYTES = INSTR_W / 8;
    localparam int BYTE_SEL_W  = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;

    typedef enum logic [1:0] {
        DEV_NONE = 2'd0,
        DEV_DROM = 2'd1,
        DEV_DRAM = 2'd2,
        DEV_IO   = 2'd3
    } dev_id_t;

    localparam dev_id_t DROM = DEV_DROM;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } drom_state_t;
endpackage

// File: rtl/drom_loader_word_assembler.sv
// Packs a little-endian byte stream into INSTR_W-bit words; a flush on a
// mid-word last byte leaves the unfilled upper lanes at zero.
module word_assembler
    import params_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               accept,
    input  logic [7:0]         byte_in,
    input  logic               last,
    output logic [INSTR_W-1:0] word,
    output logic               lane_full,
    output logic               flush
);
    logic [BYTE_SEL_W-1:0] byte_idx_q, byte_idx_d;
    logic [INSTR_W-1:0]    asm_q, asm_d;

    // word already includes the byte being accepted this cycle
    assign word      = asm_q | (INSTR_W'(byte_in) << {byte_idx_q, 3'b000});
    assign lane_full = (byte_idx_q == BYTE_SEL_W'(INSTR_BYTES - 1));
    assign flush     = accept && last && !lane_full;

    always_comb begin
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        if (accept) begin
            if (lane_full || last) begin
                byte_idx_d = '0;
                asm_d      = '0;
            end else begin
                byte_idx_d = byte_idx_q + 1'b1;
                asm_d      = word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx_q <= '0;
            asm_q      <= '0;
        end else begin
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
        end
    end
endmodule

// File: rtl/drom_loader.sv
// Instruction ROM responder: boot-loads its array from a byte stream, then
// serves zero-latency word reads and flags out-of-window/misaligned fetches.
module drom_loader
    import params_pkg::*;
#(
    parameter int                DEPTH_LOG2 = 8,
    parameter logic [ADDR_W-1:0] BASE       = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  rd,
    output logic [INSTR_W-1:0]    drom_data,
    output logic                  err,
    output logic                  hold_req,
    input  logic                  ld_valid,
    input  logic [7:0]            ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic [DEPTH_LOG2:0]   loaded
);
    localparam int DEPTH    = 1 << DEPTH_LOG2;
    localparam int ALIGN_SH = $clog2(INSTR_BYTES);

    drom_state_t          state_q, state_d;
    logic [DEPTH_LOG2:0]  ptr_q, ptr_d;
    logic [DEPTH_LOG2:0]  loaded_q, loaded_d;
    logic                 err_q, err_d;
    logic [INSTR_W-1:0]   mem_q [DEPTH];

    logic                 accept, wr_en, lane_full, flush;
    logic [INSTR_W-1:0]   asm_word;

    assign ld_ready = (state_q == LOAD) && (ptr_q < (DEPTH_LOG2+1)'(DEPTH));
    assign hold_req = (state_q == LOAD);
    assign accept   = ld_valid && ld_ready;
    assign wr_en    = accept && (lane_full || flush);
    assign loaded   = loaded_q;
    assign err      = err_q;

    word_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .accept    (accept),
        .byte_in   (ld_data),
        .last      (ld_last),
        .word      (asm_word),
        .lane_full (lane_full),
        .flush     (flush)
    );

    logic [ADDR_W-1:0] off, idx;
    logic              good;

    // addr below BASE wraps off to a huge index, so the range test needs the >= guard too
    assign off  = addr - BASE;
    assign idx  = off >> ALIGN_SH;
    assign good = (state_q == RUN) && rd && (addr >= BASE) &&
                  (idx < ADDR_W'(DEPTH)) && ((off & ADDR_W'(INSTR_BYTES - 1)) == '0);
    assign drom_data = good ? mem_q[idx[DEPTH_LOG2-1:0]] : '0;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        loaded_d = loaded_q;
        err_d    = (state_q == RUN) && rd && !good;
        if (wr_en) begin
            ptr_d = ptr_q + 1'b1;
            if (loaded_q != (DEPTH_LOG2+1)'(DEPTH))
                loaded_d = loaded_q + 1'b1;
        end
        if (state_q == LOAD && accept &&
            (ld_last || (wr_en && ptr_d == (DEPTH_LOG2+1)'(DEPTH))))
            state_d = RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= LOAD;
            ptr_q    <= '0;
            loaded_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            loaded_q <= loaded_d;
            err_q    <= err_d;
        end
    end

    // array is deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (!rst && wr_en)
            mem_q[ptr_q[DEPTH_LOG2-1:0]] <= asm_word;
    end
endmodule

// File: tb/tb_drom_loader.sv
// Directed bench for drom_loader with a 4-word array at BASE 0x100.
module tb_drom_loader;
    import params_pkg::*;

    localparam int DL = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [ADDR_W-1:0]  addr;
    logic               rd;
    logic [INSTR_W-1:0] drom_data;
    logic               err;
    logic               hold_req;
    logic               ld_valid;
    logic [7:0]         ld_data;
    logic               ld_last;
    logic               ld_ready;
    logic [DL:0]        loaded;

    int n_chk = 0;
    int n_err = 0;

    drom_loader #(.DEPTH_LOG2(DL), .BASE(32'h100)) dut (
        .clk(clk), .rst(rst), .addr(addr), .rd(rd), .drom_data(drom_data),
        .err(err), .hold_req(hold_req), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(ld_ready), .loaded(loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; rd = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        @(negedge clk);
        ld_valid = 1'b1; ld_data = b; ld_last = last;
        @(posedge clk); #1;
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        addr = a; rd = 1'b1; #1;
        chk(tag, drom_data, exp);
        @(posedge clk); #1;
        rd = 1'b0;
        chk({tag, "_noerr"}, 32'(err), 32'd0);
    endtask

    task automatic bad_read(input string tag, input logic [31:0] a);
        @(negedge clk);
        addr = a; rd = 1'b1; #1;
        chk({tag, "_data"}, drom_data, 32'd0);
        @(posedge clk); #1;
        rd = 1'b0;
        chk({tag, "_err"}, 32'(err), 32'd1);
        @(posedge clk); #1;
        chk({tag, "_err_clr"}, 32'(err), 32'd0);
    endtask

    logic [7:0]  img [12];
    logic [31:0] w;

    initial begin
        rst = 1'b1; addr = '0; rd = 1'b0;
        ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;

        // reset state and rd during LOAD
        do_reset();
        @(negedge clk);
        chk("rst_hold", 32'(hold_req), 32'd1);
        chk("rst_ready", 32'(ld_ready), 32'd1);
        chk("rst_loaded", 32'(loaded), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        addr = 32'h0FC; rd = 1'b1; #1;
        chk("load_rd_data", drom_data, 32'd0);
        @(posedge clk); #1;
        rd = 1'b0;
        chk("load_rd_err", 32'(err), 32'd0);

        // full two-word load
        send(8'h13, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
        send(8'h93, 1'b0); send(8'h00, 1'b0); send(8'h10, 1'b0); send(8'h00, 1'b1);
        chk("full_hold", 32'(hold_req), 32'd0);
        chk("full_ready", 32'(ld_ready), 32'd0);
        chk("full_loaded", 32'(loaded), 32'd2);
        read_chk("full_w0", 32'h100, 32'h0000_0013);
        read_chk("full_w1", 32'h104, 32'h0010_0093);

        // bad reads
        bad_read("bad_below", 32'h0FC);
        bad_read("bad_misal", 32'h102);
        bad_read("bad_above", 32'h110);

        // partial final word
        do_reset();
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
        send(8'hAA, 1'b1);
        chk("part_loaded", 32'(loaded), 32'd2);
        chk("part_hold", 32'(hold_req), 32'd0);
        read_chk("part_w0", 32'h100, 32'h0403_0201);
        read_chk("part_w1", 32'h104, 32'h0000_00AA);

        // array full without ld_last
        do_reset();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("fill_ready_b16", 32'(ld_ready), 32'd1);
            send(8'(8'h10 + i), 1'b0);
        end
        chk("fill_hold", 32'(hold_req), 32'd0);
        chk("fill_ready", 32'(ld_ready), 32'd0);
        chk("fill_loaded", 32'(loaded), 32'd4);
        send(8'hEE, 1'b1);
        chk("fill_b17_loaded", 32'(loaded), 32'd4);
        chk("fill_b17_ready", 32'(ld_ready), 32'd0);
        read_chk("fill_w0", 32'h100, 32'h1312_1110);
        read_chk("fill_w3", 32'h10C, 32'h1F1E_1D1C);

        // reset mid-load, with a byte offered during reset
        do_reset();
        for (int i = 0; i < 6; i++) send(8'(8'hA0 + i), 1'b0);
        @(negedge clk);
        rst = 1'b1; ld_valid = 1'b1; ld_data = 8'h55; ld_last = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        chk("mid_rst_loaded", 32'(loaded), 32'd0);
        chk("mid_rst_hold", 32'(hold_req), 32'd1);
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b1);
        chk("mid_loaded", 32'(loaded), 32'd1);
        read_chk("mid_w0", 32'h100, 32'h4433_2211);

        // backpressure: random idle gaps with garbage on ld_data
        do_reset();
        for (int i = 0; i < 12; i++) img[i] = 8'(8'h3C + 8'(i * 7));
        for (int i = 0; i < 12; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                ld_valid = 1'b0; ld_data = 8'(~img[i]); ld_last = 1'b1;
                @(posedge clk); #1;
                ld_last = 1'b0;
            end
            send(img[i], i == 11);
        end
        chk("bp_loaded", 32'(loaded), 32'd3);
        for (int k = 0; k < 3; k++) begin
            w = {img[4*k+3], img[4*k+2], img[4*k+1], img[4*k]};
            read_chk($sformatf("bp_w%0d", k), 32'h100 + 32'(4*k), w);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/drom_loader.md
# drom_loader

Instruction-memory responder for the CPU fetch path: the read side that answers the fetch unit's `addr`/`rd` requests with `drom_data`. After reset it runs a boot-load phase that fills its word array from a valid/ready byte stream, holding fetch off until loading completes. It then serves combinational word reads in the same cycle the address is presented, and flags out-of-window or misaligned reads. It sits between the address decoder's DROM region and the boot/debug byte source.

## Interface
Parameters:
- `DEPTH_LOG2`, 8, log2 of array depth in `INSTR_W`-bit words.
- `BASE`, `'0`, byte address of word 0; must be aligned to `INSTR_W/8`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `addr`  in  `ADDR_W`  byte address from fetch.
- `rd`  in  1  read request from fetch.
- `drom_data`  out  `INSTR_W`  read data; combinational.
- `err`  out  1  registered one-cycle pulse for a bad read.
- `hold_req`  out  1  high while loading; drives fetch `hold`.
- `ld_valid`  in  1  load byte valid.
- `ld_data`  in  8  load byte.
- `ld_last`  in  1  marks the final byte of the image; qualified by `ld_valid`.
- `ld_ready`  out  1  load byte accepted on this edge if `ld_valid` is also high.
- `loaded`  out  `DEPTH_LOG2+1`  number of words written since reset.

## Operation
- **States.**
  - `LOAD`: entered on reset.
  - `RUN`.
  - No other states.
- **Reset.**
  - state = `LOAD`; byte lane = 0; word pointer = 0; `loaded` = 0; `err` = 0; assembly register = 0.
  - Array contents are not cleared.
- **LOAD, byte acceptance.**
  - `hold_req` = 1.
  - `ld_ready` = 1 while word pointer < `DEPTH`.
  - An accepted byte (`ld_valid && ld_ready`) goes to lane `byte_idx`, little-endian: byte 0 is bits [7:0].
- **LOAD, word write.**
  - A word is written to `mem[ptr]` on the edge that accepts its last lane (`INSTR_W/8 - 1`).
  - The same edge increments `ptr` and `loaded`.
- **LOAD, `ld_last` handling.**
  - `ld_last` on a mid-word byte: the partial word is written with unfilled upper lanes = 0.
  - `ld_last` on an accepted byte always counts that word and moves the state to `RUN`.
- **LOAD, array full.**
  - When `ptr` reaches `DEPTH` without `ld_last`: state moves to `RUN` on that same edge and `ld_ready` drops.
- **RUN.**
  - `hold_req` = 0; `ld_ready` = 0; load inputs are ignored.
  - Only `rst` returns the block to `LOAD`.
- **Read path.**
  - A read is good when: state = `RUN`, `rd` = 1, `addr` ≥ `BASE`, index < `DEPTH`, and `addr` is aligned.
  - index = (`addr` − `BASE`) >> log2(`INSTR_W/8`).
  - On a good read, `drom_data` = `mem[index]`; otherwise `drom_data` = 0.
- **Error reporting.**
  - `err` is set on the next edge when `rd` = 1 in `RUN` and the read is not good.
  - `rd` during `LOAD` is never an error.
- **Width rules.**
  - `INSTR_W` must be a multiple of 8.
  - `loaded` saturates at `DEPTH`.

## Timing
- Read latency is 0 cycles: `drom_data` settles combinationally from `addr`, so fetch latches it on the same edge.
- A word written on edge N is readable from cycle N+1.
- `hold_req` falls in the cycle after the edge that accepts `ld_last` or fills the array, because it is decoded from registered state.
- `err` is high for exactly one cycle, one cycle after the offending `rd`.
- Backpressure: gaps in `ld_valid` leave lane and pointer unchanged, and a byte is never dropped or duplicated.
- Reset mid-load: lane, pointer and `loaded` restart at 0. The partially assembled word is discarded, and previously written words persist but are overwritten by the new load.
- Reset and `ld_valid` asserted in the same cycle: reset wins and the byte is not accepted.

## Structure
- Add to `params_pkg`:
  - the `drom_state_t` enum (`LOAD`, `RUN`);
  - `INSTR_BYTES = INSTR_W/8`;
  - `BYTE_SEL_W`.
- `ADDR_W`, `INSTR_W` and the `DROM` device id come from `params_pkg`.
- One sub-module, `word_assembler`, packs bytes into a word and reports lane-full and partial-flush.
- The top level holds the FSM, the array, the pointer and the read/error logic.

## Test plan
All cases use `INSTR_W` = 32 and `BASE` = 0x100 unless stated.

- **Full load and read.** Load bytes 13 00 00 00 93 00 10 00, with `ld_last` on the 8th byte.
  - Expect `mem[0]` = 0x00000013, `mem[1]` = 0x00100093 and `loaded` = 2.
  - Expect `hold_req` low one cycle after the final byte.
  - A read of `addr` 0x104 returns 0x00100093 in the same cycle.
- **Partial word.** Load 5 bytes ending AA with `ld_last`.
  - Expect word1 = 0x000000AA and `loaded` = 2.
- **Array full.** With `DEPTH_LOG2` = 2, stream 16 bytes without `ld_last`.
  - Expect `RUN` after byte 16, `ld_ready` = 0 from then on, and byte 17 ignored.
- **Bad reads.** In `RUN`, issue `rd` at 0x0FC, at 0x102, and at `BASE + 4*DEPTH`.
  - Each gives `drom_data` = 0 and a one-cycle `err` pulse on the next cycle.
  - `rd` during `LOAD` gives `err` = 0.
- **Reset mid-load.** Load 6 bytes, assert `rst`, then reload 4 bytes 11 22 33 44 with `ld_last`.
  - Expect `mem[0]` = 0x44332211 and `loaded` = 1.
- **Backpressure.** Toggle `ld_valid` randomly while loading 12 bytes.
  - The resulting words match a reference image packed little-endian.
